// File: rtl/deserializer_if.sv
// Serial-in / word-out bundle between a bit source, the deserializer and the word sink.
// No logic; signals only.
// Backpressure: ready is driven by the word sink and qualifies valid.
interface deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  serial_in;
    logic                  enable;
    logic                  start;
    logic [DATA_WIDTH-1:0] parallel_out;
    logic                  valid;
    logic                  ready;
    logic                  frame_err;
    logic                  overflow;

    // Bit source plus word sink side (drives the serial stream and ready).
    modport master (
        output serial_in, enable, start, ready,
        input  parallel_out, valid, frame_err, overflow
    );

    // Deserializer side.
    modport slave (
        input  serial_in, enable, start, ready,
        output parallel_out, valid, frame_err, overflow
    );
endinterface

// File: rtl/deserializer.sv
// Rebuilds MSB-first serial words framed by a start strobe into a one-entry output buffer.
// Latency: valid rises on the edge that samples the last bit of a word.
// Backpressure: a word completing while the buffer is full and not draining is dropped (overflow).
module deserializer #(
    parameter int DATA_WIDTH    = 8,
    parameter int COUNTER_WIDTH = $clog2(DATA_WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    deserializer_if.slave io
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [COUNTER_WIDTH-1:0] LAST_CNT = COUNTER_WIDTH'(DATA_WIDTH - 1);

    state_t                   state, state_nxt;
    logic [DATA_WIDTH-1:0]    shift_reg, shift_nxt;
    logic [COUNTER_WIDTH-1:0] bit_cnt, cnt_nxt;
    logic                     word_done;
    logic                     abort;

    // Frame tracking: decides where the sampled bit goes and whether a word ends or aborts.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        cnt_nxt   = bit_cnt;
        word_done = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                // Stray bits without start are silently ignored.
                if (io.enable && io.start) begin
                    shift_nxt = {shift_reg[DATA_WIDTH-2:0], io.serial_in};
                    cnt_nxt   = COUNTER_WIDTH'(1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (!io.enable) begin
                    // A gap inside a frame kills it.
                    abort     = 1'b1;
                    shift_nxt = '0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (io.start) begin
                    // Restart: the new frame begins with this bit; older bits shift out unused.
                    abort     = 1'b1;
                    shift_nxt = {shift_reg[DATA_WIDTH-2:0], io.serial_in};
                    cnt_nxt   = COUNTER_WIDTH'(1);
                end else begin
                    shift_nxt = {shift_reg[DATA_WIDTH-2:0], io.serial_in};
                    if (bit_cnt == LAST_CNT) begin
                        word_done = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = bit_cnt + COUNTER_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Frame state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= cnt_nxt;
        end
    end

    // Output buffer: load on completion if empty or draining, otherwise drop and flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io.parallel_out <= '0;
            io.valid        <= 1'b0;
            io.frame_err    <= 1'b0;
            io.overflow     <= 1'b0;
        end else begin
            io.frame_err <= abort;
            io.overflow  <= 1'b0;
            if (word_done) begin
                if (!io.valid || io.ready) begin
                    io.parallel_out <= shift_nxt;
                    io.valid        <= 1'b1;
                end else begin
                    io.overflow <= 1'b1;
                end
            end else if (io.valid && io.ready) begin
                io.valid <= 1'b0;
            end
        end
    end
endmodule
